// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for pipe_stage_reg: occupancy encoding and MEM/WB control bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;

    // Skid is only ever filled behind a valid main entry, so two valid bits are enough.
    function automatic occ_e occ_of(input logic main_valid, input logic skid_valid);
        occ_e occ;
        if (skid_valid) begin
            occ = OCC_TWO;
        end else if (main_valid) begin
            occ = OCC_ONE;
        end else begin
            occ = OCC_EMPTY;
        end
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline-stage entry: valid bit plus {ctrl, data, rd} payload.
// clr kills the entry (valid and ctrl zeroed); data/rd keep their last loaded value.
module pipe_slot #(
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_en,
    input  logic              clr,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    input  logic [RD_W-1:0]   rd_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    output logic [RD_W-1:0]   rd_q
);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_en) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid; optional perf counters under PIPE_STAGE_PERF_EN.
//
//   state     | meaning
//   OCC_EMPTY | no beat held, dn_valid_o=0
//   OCC_ONE   | main holds the beat presented downstream
//   OCC_TWO   | main presented, skid holds the younger beat, up_ready_o=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 2,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [RD_W-1:0]   up_rd_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [RD_W-1:0]   dn_rd_o,
    output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [RD_W-1:0]   main_rd;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [RD_W-1:0]   skid_rd;

    logic              main_load;
    logic              main_clr;
    logic              skid_load;
    logic              skid_clr;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic [RD_W-1:0]   main_rd_d;

    occ_e occ;
    logic up_xfer;
    logic dn_xfer;

    assign occ        = occ_of(main_valid, skid_valid);
    assign up_ready_o = !skid_valid;
    assign up_xfer    = up_valid_i && up_ready_o;
    assign dn_xfer    = main_valid && dn_ready_i;

    always_comb begin
        main_load   = 1'b0;
        main_clr    = 1'b0;
        skid_load   = 1'b0;
        skid_clr    = 1'b0;
        main_ctrl_d = up_ctrl_i;
        main_data_d = up_data_i;
        main_rd_d   = up_rd_i;

        if (flush_i) begin
            // A same-cycle dn_xfer already completed on the wire; the upstream beat is dropped.
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            unique case (occ)
                OCC_EMPTY: begin
                    main_load = up_xfer;
                end
                OCC_ONE: begin
                    if (up_xfer && dn_xfer) begin
                        main_load = 1'b1;
                    end else if (up_xfer) begin
                        skid_load = 1'b1;
                    end else if (dn_xfer) begin
                        main_clr = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (dn_xfer) begin
                        main_load   = 1'b1;
                        skid_clr    = 1'b1;
                        main_ctrl_d = skid_ctrl;
                        main_data_d = skid_data;
                        main_rd_d   = skid_rd;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_en (main_load),
        .clr     (main_clr),
        .ctrl_d  (main_ctrl_d),
        .data_d  (main_data_d),
        .rd_d    (main_rd_d),
        .valid_q (main_valid),
        .ctrl_q  (main_ctrl),
        .data_q  (main_data),
        .rd_q    (main_rd)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_en (skid_load),
        .clr     (skid_clr),
        .ctrl_d  (up_ctrl_i),
        .data_d  (up_data_i),
        .rd_d    (up_rd_i),
        .valid_q (skid_valid),
        .ctrl_q  (skid_ctrl),
        .data_q  (skid_data),
        .rd_q    (skid_rd)
    );

    assign dn_valid_o  = main_valid;
    assign dn_ctrl_o   = main_ctrl & {CTRL_W{main_valid}};
    assign dn_data_o   = main_data;
    assign dn_rd_o     = main_rd;
    assign occupancy_o = occ;

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (dn_valid_o && !dn_ready_i && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (!dn_valid_o && (bubble_cnt_o != CNT_MAX)) begin
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed beats, expected queue popped by a downstream monitor.
module tb_pipe_stage_reg;

    localparam int unsigned TB_CNT_W = 4;

    typedef struct packed {
        logic [1:0]  c;
        logic [63:0] d;
        logic [4:0]  r;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        up_valid;
    logic        up_ready;
    logic [1:0]  up_ctrl;
    logic [63:0] up_data;
    logic [4:0]  up_rd;
    logic        dn_valid;
    logic        dn_ready;
    logic [1:0]  dn_ctrl;
    logic [63:0] dn_data;
    logic [4:0]  dn_rd;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] bubble_cnt;
`endif

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W (2),
        .DATA_W (64),
        .RD_W   (5),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush),
        .up_valid_i   (up_valid),
        .up_ready_o   (up_ready),
        .up_ctrl_i    (up_ctrl),
        .up_data_i    (up_data),
        .up_rd_i      (up_rd),
        .dn_valid_o   (dn_valid),
        .dn_ready_i   (dn_ready),
        .dn_ctrl_o    (dn_ctrl),
        .dn_data_o    (dn_data),
        .dn_rd_o      (dn_rd),
        .occupancy_o  (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        up_valid = 1'b0;
    endtask

    // Offer a beat until accepted; the expected beat is queued on the accepting edge.
    task automatic send(input logic [1:0] c, input logic [63:0] d, input logic [4:0] r);
        bit done = 1'b0;
        up_valid = 1'b1;
        up_ctrl  = c;
        up_data  = d;
        up_rd    = r;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = up_ready && !flush && rst_n;
            @(posedge clk);
            if (done) exp_q.push_back(beat_t'{c, d, r});
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Downstream monitor: every completed dn transfer must match the oldest expected beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && dn_valid === 1'b1 && dn_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", dn_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("dn_ctrl", 64'(dn_ctrl), 64'(b.c));
                    chk("dn_data", dn_data, b.d);
                    chk("dn_rd", 64'(dn_rd), 64'(b.r));
                end
            end
            if (rst_n === 1'b1 && dn_valid === 1'b0) chk("bubble_ctrl", 64'(dn_ctrl), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b0;
        up_ctrl  = '0;
        up_data  = '0;
        up_rd    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_dn_ctrl", 64'(dn_ctrl), 64'd0);
        chk("rst_dn_data", dn_data, 64'd0);
        chk("rst_dn_rd", 64'(dn_rd), 64'd0);
        chk("rst_up_ready", 64'(up_ready), 64'd1);

        // Streaming: each beat visible one edge after acceptance, occupancy stays at one.
        dn_ready = 1'b1;
        send(2'b01, 64'h1111_1111_1111_1111, 5'd1);
        chk("stream1_data", dn_data, 64'h1111_1111_1111_1111);
        chk("stream1_occ", 64'(occupancy), 64'd1);
        send(2'b01, 64'h2222_2222_2222_2222, 5'd2);
        chk("stream2_data", dn_data, 64'h2222_2222_2222_2222);
        chk("stream2_occ", 64'(occupancy), 64'd1);
        chk("stream2_up_ready", 64'(up_ready), 64'd1);
        send(2'b01, 64'h3333_3333_3333_3333, 5'd3);
        chk("stream3_data", dn_data, 64'h3333_3333_3333_3333);
        chk("stream3_occ", 64'(occupancy), 64'd1);
        chk("stream3_up_ready", 64'(up_ready), 64'd1);
        idle();
        step();
        chk("stream_empty_occ", 64'(occupancy), 64'd0);
        chk("stream_empty_valid", 64'(dn_valid), 64'd0);

        // Backpressure: A and B held, C waits upstream, then all three drain in order.
        dn_ready = 1'b0;
        send(2'b01, 64'h0000_0000_0000_00A0, 5'd10);
        chk("bp_a_occ", 64'(occupancy), 64'd1);
        send(2'b10, 64'h0000_0000_0000_00B0, 5'd11);
        chk("bp_b_occ", 64'(occupancy), 64'd2);
        chk("bp_b_up_ready", 64'(up_ready), 64'd0);
        up_valid = 1'b1;
        up_ctrl  = 2'b11;
        up_data  = 64'h0000_0000_0000_00C0;
        up_rd    = 5'd12;
        repeat (3) step();
        chk("bp_hold_occ", 64'(occupancy), 64'd2);
        chk("bp_hold_up_ready", 64'(up_ready), 64'd0);
        chk("bp_hold_head", dn_data, 64'h0000_0000_0000_00A0);
        dn_ready = 1'b1;
        send(2'b11, 64'h0000_0000_0000_00C0, 5'd12);
        idle();
        drain("bp_drain");
        step();
        chk("bp_end_occ", 64'(occupancy), 64'd0);

        // Flush with a same-cycle dn transfer (delivered) and up transfer (dropped).
        send(2'b11, 64'h0000_0000_0000_0D0D, 5'd13);
        up_data = 64'h0000_0000_0000_0E0E;
        up_rd   = 5'd14;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush1_occ", 64'(occupancy), 64'd0);
        chk("flush1_valid", 64'(dn_valid), 64'd0);
        repeat (3) step();
        chk("flush1_q", 64'(exp_q.size()), 64'd0);

        // Flush at two entries, upstream beat offered the same cycle.
        dn_ready = 1'b0;
        send(2'b11, 64'hAAAA_AAAA_AAAA_AAAA, 5'd20);
        send(2'b11, 64'hBBBB_BBBB_BBBB_BBBB, 5'd21);
        chk("flush2_pre_occ", 64'(occupancy), 64'd2);
        up_ctrl = 2'b11;
        up_data = 64'hCCCC_CCCC_CCCC_CCCC;
        up_rd   = 5'd22;
        flush   = 1'b1;
        step();
        exp_q.delete();
        flush = 1'b0;
        idle();
        chk("flush2_valid", 64'(dn_valid), 64'd0);
        chk("flush2_ctrl", 64'(dn_ctrl), 64'd0);
        chk("flush2_occ", 64'(occupancy), 64'd0);
        chk("flush2_up_ready", 64'(up_ready), 64'd1);
        chk("flush2_data_hold", dn_data, 64'hAAAA_AAAA_AAAA_AAAA);
        dn_ready = 1'b1;
        repeat (4) step();
        chk("flush2_q", 64'(exp_q.size()), 64'd0);

        // Reset mid-traffic at two entries.
        dn_ready = 1'b0;
        send(2'b01, 64'h0000_0000_0000_5151, 5'd5);
        send(2'b10, 64'h0000_0000_0000_5252, 5'd6);
        idle();
        chk("mrst_pre_occ", 64'(occupancy), 64'd2);
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        rst_n = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        rst_n = 1'b1;
        chk("mrst_occ", 64'(occupancy), 64'd0);
        chk("mrst_valid", 64'(dn_valid), 64'd0);
        chk("mrst_ctrl", 64'(dn_ctrl), 64'd0);
        chk("mrst_data", dn_data, 64'd0);
        chk("mrst_up_ready", 64'(up_ready), 64'd1);

`ifdef PIPE_STAGE_PERF_EN
        chk("perf_rst_stall", 64'(stall_cnt), 64'd0);
        chk("perf_rst_bubble", 64'(bubble_cnt), 64'd0);
        repeat (3) step();
        chk("perf_bubble3", 64'(bubble_cnt), 64'd3);
        chk("perf_stall0", 64'(stall_cnt), 64'd0);
        send(2'b01, 64'h0000_0000_0000_7777, 5'd7);
        idle();
        chk("perf_bubble4", 64'(bubble_cnt), 64'd4);
        repeat (20) step();
        chk("perf_stall_sat", 64'(stall_cnt), 64'd15);
        chk("perf_bubble_hold", 64'(bubble_cnt), 64'd4);
        dn_ready = 1'b1;
        drain("perf_drain");
`endif

        dn_ready = 1'b1;
        idle();
        repeat (2) step();
        chk("final_q", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
